// File: rtl/execute_memory_register.sv
// ---------------------------------------------------------------------------
// execute_memory_register
//   Execute -> Memory pipeline boundary for the 16-bit CPU. It uses a
//   valid/ready handshake with a 2-entry skid buffer. The main register
//   drives the outputs. The skid register holds one overflow entry, so a
//   Memory-stage stall never reaches Execute combinationally: in_ready is a
//   flop.
//
//   Optional feature (macro EM_STALL_COUNT_EN): adds the stall_cycles output.
//   It counts cycles with out_valid & !out_ready and saturates at 16'hFFFF.
//   Only rst_n clears it.
//
// Ports
//   clk, rst_n          clock (rising), async active-low reset
//   flush               synchronous kill of all held entries
//   in_valid/in_ready   Execute-side handshake (in_ready registered)
//   *_in                Execute control bits, mm_in, alu_result_in, store_data_in
//   out_valid/out_ready Memory-side handshake
//   *_out               held entry (1-bit controls gated by out_valid)
//   occupancy           entries held: 0, 1 or 2
//   stall_cycles        (EM_STALL_COUNT_EN only) saturating stall counter
// ---------------------------------------------------------------------------
module execute_memory_register #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              wbs_in,
    input  logic              wm_in,
    input  logic              am_in,
    input  logic              ni_in,
    input  logic              wce_in,
    input  logic              wme1_in,
    input  logic              wme2_in,
    input  logic [1:0]        mm_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] store_data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wbs_out,
    output logic              wm_out,
    output logic              am_out,
    output logic              ni_out,
    output logic              wce_out,
    output logic              wme1_out,
    output logic              wme2_out,
    output logic [1:0]        mm_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] store_data_out,
    output logic [1:0]        occupancy
`ifdef EM_STALL_COUNT_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    typedef struct packed {
        logic              wbs, wm, am, ni, wce, wme1, wme2;
        logic [1:0]        mm;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] st;
    } entry_t;

    // Flush clears the 1-bit control fields. mm and the data are left alone
    // so the outputs keep their last value while invalid.
    function automatic entry_t clear_ctrl(entry_t e);
        entry_t r;
        r      = e;
        r.wbs  = 1'b0;
        r.wm   = 1'b0;
        r.am   = 1'b0;
        r.ni   = 1'b0;
        r.wce  = 1'b0;
        r.wme1 = 1'b0;
        r.wme2 = 1'b0;
        return r;
    endfunction

    state_t state_q;
    entry_t main_q, skid_q, in_e;
    logic   in_ready_q;
    logic   accept, emit;

    assign in_e = '{wbs: wbs_in, wm: wm_in, am: am_in, ni: ni_in, wce: wce_in,
                    wme1: wme1_in, wme2: wme2_in, mm: mm_in,
                    alu: alu_result_in, st: store_data_in};

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign accept    = in_valid & in_ready_q;
    assign emit      = out_valid & out_ready;

    // in_ready_q is updated alongside the state. It is low only when the
    // next state is TWO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= clear_ctrl(main_q);
            skid_q     <= clear_ctrl(skid_q);
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_q  <= in_e;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        main_q <= in_e;
                    end else if (accept) begin
                        skid_q     <= in_e;
                        state_q    <= TWO;
                        in_ready_q <= 1'b0;
                    end else if (emit) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    if (emit) begin
                        main_q     <= skid_q;
                        state_q    <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign occupancy      = state_q;
    assign wbs_out        = main_q.wbs  & out_valid;
    assign wm_out         = main_q.wm   & out_valid;
    assign am_out         = main_q.am   & out_valid;
    assign ni_out         = main_q.ni   & out_valid;
    assign wce_out        = main_q.wce  & out_valid;
    assign wme1_out       = main_q.wme1 & out_valid;
    assign wme2_out       = main_q.wme2 & out_valid;
    assign mm_out         = main_q.mm;
    assign alu_result_out = main_q.alu;
    assign store_data_out = main_q.st;

`ifdef EM_STALL_COUNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_q <= 16'd0;
        else if (out_valid && !out_ready && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_execute_memory_register.sv
module tb_execute_memory_register;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic wbs_in, wm_in, am_in, ni_in, wce_in, wme1_in, wme2_in;
    logic wbs_out, wm_out, am_out, ni_out, wce_out, wme1_out, wme2_out;
    logic [1:0] mm_in, mm_out, occupancy;
    logic [DW-1:0] alu_result_in, store_data_in, alu_result_out, store_data_out;
`ifdef EM_STALL_COUNT_EN
    logic [15:0] stall_cycles;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    execute_memory_register #(.DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .wbs_in(wbs_in), .wm_in(wm_in), .am_in(am_in), .ni_in(ni_in),
        .wce_in(wce_in), .wme1_in(wme1_in), .wme2_in(wme2_in),
        .mm_in(mm_in), .alu_result_in(alu_result_in), .store_data_in(store_data_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .wbs_out(wbs_out), .wm_out(wm_out), .am_out(am_out), .ni_out(ni_out),
        .wce_out(wce_out), .wme1_out(wme1_out), .wme2_out(wme2_out),
        .mm_out(mm_out), .alu_result_out(alu_result_out), .store_data_out(store_data_out),
        .occupancy(occupancy)
`ifdef EM_STALL_COUNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    // Entry layout: {wbs,wm,am,ni,wce,wme1,wme2, mm[1:0], alu[15:0], store[15:0]}
    logic [40:0] obs;
    assign obs = {wbs_out, wm_out, am_out, ni_out, wce_out, wme1_out, wme2_out,
                  mm_out, alu_result_out, store_data_out};

    task automatic set_in(input logic [40:0] e);
        {wbs_in, wm_in, am_in, ni_in, wce_in, wme1_in, wme2_in,
         mm_in, alu_result_in, store_data_in} = e;
    endtask

    // Advance one cycle. Returns at the negedge, where outputs are sampled
    // and the next inputs are driven.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_in('0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %0b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %0b exp 1", in_ready); else pass_cnt++;
        total_cnt++; if (occupancy !== 2'd0) $display("FAIL rst_occupancy got %0d exp 0", occupancy); else pass_cnt++;
        total_cnt++; if (obs !== 41'd0) $display("FAIL rst_outputs got %h exp 0", obs); else pass_cnt++;
    endtask

    task automatic test_passthrough();
        set_in('0); wm_in = 1'b1; mm_in = 2'b10; alu_result_in = 16'h1234;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL pt_valid got %0b exp 1", out_valid); else pass_cnt++;
        total_cnt++; if (alu_result_out !== 16'h1234) $display("FAIL pt_alu got %h exp 1234", alu_result_out); else pass_cnt++;
        total_cnt++; if (mm_out !== 2'b10) $display("FAIL pt_mm got %b exp 10", mm_out); else pass_cnt++;
        total_cnt++; if (wm_out !== 1'b1) $display("FAIL pt_wm got %b exp 1", wm_out); else pass_cnt++;
        total_cnt++; if (occupancy !== 2'd1) $display("FAIL pt_occ got %0d exp 1", occupancy); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b0 || wm_out !== 1'b0) $display("FAIL pt_drain_gate got v=%b wm=%b exp 0 0", out_valid, wm_out); else pass_cnt++;
        total_cnt++; if (alu_result_out !== 16'h1234 || mm_out !== 2'b10) $display("FAIL pt_hold_data got %h/%b exp 1234/10", alu_result_out, mm_out); else pass_cnt++;
    endtask

    task automatic test_skid_fill();
        out_ready = 1'b0; set_in('0);
        in_valid = 1'b1; alu_result_in = 16'h0001;
        tick();
        alu_result_in = 16'h0002;
        tick();
        in_valid = 1'b0;
        total_cnt++; if (occupancy !== 2'd2) $display("FAIL skid_occ got %0d exp 2", occupancy); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL skid_in_ready got %0b exp 0", in_ready); else pass_cnt++;
        total_cnt++; if (alu_result_out !== 16'h0001) $display("FAIL skid_head got %h exp 0001", alu_result_out); else pass_cnt++;
        tick();
        total_cnt++; if (alu_result_out !== 16'h0001 || out_valid !== 1'b1) $display("FAIL skid_hold got %h v=%b exp 0001 1", alu_result_out, out_valid); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        total_cnt++; if (alu_result_out !== 16'h0002 || occupancy !== 2'd1) $display("FAIL skid_second got %h occ=%0d exp 0002 1", alu_result_out, occupancy); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL skid_ready_back got %0b exp 1", in_ready); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b0 || occupancy !== 2'd0) $display("FAIL skid_drain got v=%b occ=%0d exp 0 0", out_valid, occupancy); else pass_cnt++;
    endtask

    task automatic test_streaming();
        set_in('0); in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            alu_result_in = 16'(i);
            store_data_in = 16'(i * 3);
            tick();
            total_cnt++;
            if (out_valid !== 1'b1 || alu_result_out !== 16'(i) || store_data_out !== 16'(i * 3) || occupancy !== 2'd1)
                $display("FAIL stream_%0d got v=%b alu=%h st=%h occ=%0d exp 1 %h %h 1", i, out_valid, alu_result_out, store_data_out, occupancy, 16'(i), 16'(i * 3));
            else pass_cnt++;
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        set_in('0); wm_in = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
        alu_result_in = 16'h00A1; tick();
        alu_result_in = 16'h00A2; tick();
        total_cnt++; if (occupancy !== 2'd2) $display("FAIL flush_pre_occ got %0d exp 2", occupancy); else pass_cnt++;
        flush = 1'b1; alu_result_in = 16'hBEEF;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        total_cnt++; if (out_valid !== 1'b0 || wm_out !== 1'b0) $display("FAIL flush_gate got v=%b wm=%b exp 0 0", out_valid, wm_out); else pass_cnt++;
        total_cnt++; if (occupancy !== 2'd0 || in_ready !== 1'b1) $display("FAIL flush_state got occ=%0d rdy=%b exp 0 1", occupancy, in_ready); else pass_cnt++;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (out_valid !== 1'b0 || alu_result_out === 16'hBEEF) $display("FAIL flush_no_beef got v=%b alu=%h exp v=0 alu!=beef", out_valid, alu_result_out);
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        set_in('0); out_ready = 1'b0; in_valid = 1'b1;
        alu_result_in = 16'h0011; tick();
        alu_result_in = 16'h0022; tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) $display("FAIL arst_immediate got v=%b rdy=%b occ=%0d exp 0 1 0", out_valid, in_ready, occupancy); else pass_cnt++;
        total_cnt++; if (alu_result_out !== 16'h0000) $display("FAIL arst_data got %h exp 0000", alu_result_out); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        set_in({7'b1010101, 2'b01, 16'hA5A5, 16'h5A5A});
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        total_cnt++; if (out_valid !== 1'b1 || obs !== {7'b1010101, 2'b01, 16'hA5A5, 16'h5A5A}) $display("FAIL arst_first_push got v=%b %h", out_valid, obs); else pass_cnt++;
        tick();
    endtask

`ifdef EM_STALL_COUNT_EN
    task automatic test_stall_count();
        apply_reset();
        set_in('0); in_valid = 1'b1; out_ready = 1'b0; alu_result_in = 16'h0777;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        total_cnt++; if (stall_cycles !== 16'd5) $display("FAIL stall_count got %0d exp 5", stall_cycles); else pass_cnt++;
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        total_cnt++; if (stall_cycles !== 16'd5) $display("FAIL stall_after_flush got %0d exp 5", stall_cycles); else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        total_cnt++; if (stall_cycles !== 16'd0) $display("FAIL stall_reset got %0d exp 0", stall_cycles); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask
`endif

    // Reference model: a FIFO of at most two entries. The model tracks the
    // last entry that was at the head, because mm/data hold it while empty.
    task automatic test_random();
        logic [40:0] q[$];
        logic [40:0] last, exp_obs;
        logic        acc, emt;
        int          stall_m;
        apply_reset();
        last = '0; stall_m = 0;
        for (int c = 0; c < 400; c++) begin
            exp_obs = (q.size() != 0) ? q[0] : {7'b0, last[33:0]};
            total_cnt++;
            if (out_valid !== (q.size() != 0) || occupancy !== 2'(q.size()) || in_ready !== (q.size() < 2))
                $display("FAIL rand_hs_%0d got v=%b occ=%0d rdy=%b exp model occ=%0d", c, out_valid, occupancy, in_ready, q.size());
            else pass_cnt++;
            total_cnt++;
            if (obs !== exp_obs) $display("FAIL rand_data_%0d got %h exp %h", c, obs, exp_obs);
            else pass_cnt++;
`ifdef EM_STALL_COUNT_EN
            total_cnt++;
            if (stall_cycles !== 16'(stall_m)) $display("FAIL rand_stall_%0d got %0d exp %0d", c, stall_cycles, stall_m);
            else pass_cnt++;
`endif
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            set_in({7'($urandom), 2'($urandom), 16'($urandom), 16'($urandom)});
            acc = in_valid && (q.size() < 2);
            emt = (q.size() != 0) && out_ready;
            if (q.size() != 0 && !out_ready && stall_m < 65535) stall_m++;
            if (flush) q.delete();
            else begin
                if (emt) void'(q.pop_front());
                if (acc) q.push_back({wbs_in, wm_in, am_in, ni_in, wce_in, wme1_in, wme2_in,
                                      mm_in, alu_result_in, store_data_in});
            end
            if (q.size() != 0) last = q[0];
            tick();
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_skid_fill();
        test_streaming();
        test_flush();
        test_async_reset();
`ifdef EM_STALL_COUNT_EN
        test_stall_count();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
